clken_gen: RTL and testbench

- Parametrised clock-enable generator for the system clock domain.
- Replaces the fixed inline divider that produced the CPU, VIA phase-2 and VIA 4x enables.
- Generalised to NUM_CH channels, runtime turbo scaling with clamping, and frame-aligned mode changes.
- Adds a pause request/acknowledge handshake so the SPI loader can halt the CPU cleanly, plus a delayed copy of channel 0 for CPU output registering.

---
 rtl/clken_pkg.sv | 40 ++++
 rtl/clken_chan.sv | 52 +++++
 rtl/clken_gen.sv | 111 +++++++++++
 tb/tb_clken_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// clken_pkg: shared constants and helpers for the clock-enable generator.
// Holds turbo encodings, exponent packing helpers and a constant clog2.
package clken_pkg;

    localparam int EXP_W   = 3;
    localparam int TURBO_W = 2;

    // Turbo encodings (effective exponent reduction)
    localparam logic [TURBO_W-1:0] T1MHZ = 2'd0;
    localparam logic [TURBO_W-1:0] T2MHZ = 2'd1;
    localparam logic [TURBO_W-1:0] T4MHZ = 2'd2;

    // Constant-evaluable ceiling log2, never below 1 bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Extract channel ch's base exponent from the packed vector
    // (channel 0 occupies the least significant field).
    function automatic logic [EXP_W-1:0] ch_exp(
        input logic [63:0] pk_exp,
        input int          ch
    );
        return pk_exp[ch*EXP_W +: EXP_W];
    endfunction

    // Base exponent minus turbo, saturating at zero.
    function automatic logic [EXP_W-1:0] eff_exp(
        input logic [EXP_W-1:0]   base,
        input logic [TURBO_W-1:0] turbo
    );
        logic [EXP_W-1:0] t;
        t = EXP_W'(turbo);
        return (base > t) ? (base - t) : '0;
    endfunction

endpackage

// File: rtl/clken_chan.sv
// clken_chan: one enable channel. Fires in the active window when the
// position is aligned to 2^i_exp, unless paused and pausable.
//   clk, reset_n   : clock, async active-low reset
//   i_pos          : frame position
//   i_exp          : effective period exponent
//   i_paused       : frame-aligned pause state
//   i_pausable     : this channel obeys pause
//   o_clken        : registered enable pulse
module clken_chan
    import clken_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int ACTIVE_LEN = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] i_pos,
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_paused,
    input  logic             i_pausable,
    output logic             o_clken
);

    // Wide enough that a mask of any exponent never truncates.
    localparam int PW = CNT_W + (1 << EXP_W);
    localparam logic [CNT_W:0] ACT_END = (CNT_W+1)'(ACTIVE_LEN);

    logic [PW-1:0] w_pos_x;
    logic [PW-1:0] w_mask;
    logic          w_active;
    logic          w_aligned;
    logic          w_block;
    logic          r_clken;

    assign w_pos_x   = PW'(i_pos);
    // e = 0 gives an empty mask, so every active cycle aligns.
    assign w_mask    = (PW'(1) << i_exp) - PW'(1);
    assign w_active  = ({1'b0, i_pos} < ACT_END);
    assign w_aligned = ((w_pos_x & w_mask) == '0);
    assign w_block   = i_paused & i_pausable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clken <= 1'b0;
        end else begin
            r_clken <= w_active & w_aligned & ~w_block;
        end
    end

    assign o_clken = r_clken;

endmodule

// File: rtl/clken_gen.sv
// clken_gen: frame-based clock-enable generator with turbo scaling
// and a pause handshake for pausable channels.
//   clk, reset_n : system clock, async active-low reset
//   turbo        : requested speed (sampled and clamped at frame wrap)
//   pause_req    : level request to stop pausable channels
//   pause_ack    : pausable channels are stopped
//   clken        : registered enable per channel
//   clken0_d1    : clken[0] delayed one clock
//   frame_start  : pulse coincident with pos == 0
//   pos          : frame position
module clken_gen
    import clken_pkg::*;
#(
    parameter int                      FRAME_LEN   = 25,
    parameter int                      ACTIVE_LEN  = 16,
    parameter int                      NUM_CH      = 3,
    parameter logic [EXP_W*NUM_CH-1:0] CH_EXP      = {3'd4, 3'd4, 3'd2},
    parameter logic [NUM_CH-1:0]       CH_PAUSABLE = 3'b001,
    parameter int                      MAX_TURBO   = int'(T4MHZ),
    localparam int                     CNT_W       = clog2(FRAME_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         turbo,
    input  logic               pause_req,
    output logic               pause_ack,
    output logic [NUM_CH-1:0]  clken,
    output logic               clken0_d1,
    output logic               frame_start,
    output logic [CNT_W-1:0]   pos
);

    localparam logic [CNT_W-1:0]   LAST_POS  = CNT_W'(FRAME_LEN - 1);
    localparam logic [TURBO_W-1:0] TURBO_CAP = TURBO_W'(MAX_TURBO);
    localparam logic [63:0]        EXP_VEC   = 64'(CH_EXP);

    logic [CNT_W-1:0]   r_pos;
    logic [TURBO_W-1:0] r_turbo_eff;
    logic               r_paused;
    logic               r_pause_ack;
    logic               r_frame_start;
    logic               r_clken0_d1;

    logic               w_wrap;
    logic [TURBO_W-1:0] w_turbo_clamped;
    logic [NUM_CH-1:0]  w_clken;

    assign w_wrap          = (r_pos == LAST_POS);
    assign w_turbo_clamped = (turbo > TURBO_CAP) ? TURBO_CAP : turbo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= '0;
        end else if (w_wrap) begin
            r_pos <= '0;
        end else begin
            r_pos <= r_pos + 1'b1;
        end
    end

    // Mode changes only land at the wrap so no period is cut short.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_turbo_eff <= T1MHZ;
            r_paused    <= 1'b0;
        end else if (w_wrap) begin
            r_turbo_eff <= w_turbo_clamped;
            r_paused    <= pause_req;
        end
    end

    // Ack lags paused by one clock so it lines up with the first
    // suppressed enable slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pause_ack   <= 1'b0;
            r_frame_start <= 1'b0;
            r_clken0_d1   <= 1'b0;
        end else begin
            r_pause_ack   <= r_paused;
            r_frame_start <= w_wrap;
            r_clken0_d1   <= w_clken[0];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic [EXP_W-1:0] w_exp;

        assign w_exp = eff_exp(ch_exp(EXP_VEC, g), r_turbo_eff);

        clken_chan #(
            .CNT_W      (CNT_W),
            .ACTIVE_LEN (ACTIVE_LEN)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_pos      (r_pos),
            .i_exp      (w_exp),
            .i_paused   (r_paused),
            .i_pausable (CH_PAUSABLE[g]),
            .o_clken    (w_clken[g])
        );
    end

    assign pos         = r_pos;
    assign clken       = w_clken;
    assign clken0_d1   = r_clken0_d1;
    assign frame_start = r_frame_start;
    assign pause_ack   = r_pause_ack;

endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: directed scenarios plus randomized turbo/pause/reset
// traffic checked against a cycle-level behavioural model.
module tb_clken_gen;

    localparam int FL = 25;
    localparam int AL = 16;
    localparam int NC = 3;
    localparam int EXPS [NC] = '{2, 4, 4};
    localparam logic [NC-1:0] PZ = 3'b001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    turbo = 2'd0;
    logic          pause_req = 1'b0;
    logic          pause_ack;
    logic [NC-1:0] clken;
    logic          clken0_d1;
    logic          frame_start;
    logic [4:0]    pos;

    int n_cmp = 0;
    int n_bad = 0;

    clken_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .turbo       (turbo),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .clken       (clken),
        .clken0_d1   (clken0_d1),
        .frame_start (frame_start),
        .pos         (pos)
    );

    always #5 clk = ~clk;

    // Behavioural model: frame counter, wrap-sampled mode, enables
    // from modular arithmetic on the position.
    int            m_pos = 0;
    int            m_teff = 0;
    bit            m_paused = 1'b0;
    logic [NC-1:0] m_clken = '0;
    bit            m_d1 = 1'b0;
    bit            m_fs = 1'b0;
    bit            m_ack = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = 0; m_teff = 0; m_paused = 0;
            m_clken = '0; m_d1 = 0; m_fs = 0; m_ack = 0;
        end else begin
            logic [NC-1:0] nc;
            int e;
            for (int i = 0; i < NC; i++) begin
                e = EXPS[i] - m_teff;
                if (e < 0) e = 0;
                nc[i] = (m_pos < AL) && (m_pos % (1 << e) == 0)
                        && !(m_paused && PZ[i]);
            end
            m_d1    = m_clken[0];
            m_fs    = (m_pos == FL - 1);
            m_ack   = m_paused;
            m_clken = nc;
            if (m_pos == FL - 1) begin
                m_pos    = 0;
                m_teff   = (turbo > 2'd2) ? 2 : int'(turbo);
                m_paused = pause_req;
            end else begin
                m_pos++;
            end
        end
    end

    task automatic wait_pos(input int p);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_pos == p) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_pos: pos %0d never reached (dut pos %0d)", p, pos);
    endtask

    task automatic test_reset();
        int c0 = 0, c1 = 0, c2 = 0, fs_at = -1;
        logic prev0 = 1'b0;
        reset_n = 0; turbo = 0; pause_req = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pos, clken, clken0_d1, frame_start, pause_ack} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b required 0",
                     {pos, clken, clken0_d1, frame_start, pause_ack});
        end
        reset_n = 1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
            if (clken[2]) c2++;
            if (frame_start && fs_at < 0) fs_at = k;
            n_cmp++;
            if (clken0_d1 !== prev0) begin
                n_bad++;
                $display("FAIL d1_follow k=%0d: got %b required %b",
                         k, clken0_d1, prev0);
            end
            prev0 = clken[0];
            if (k == 1) begin
                n_cmp++;
                if ({pos, clken} !== {5'd1, 3'b111}) begin
                    n_bad++;
                    $display("FAIL first_pulse: got %b required %b",
                             {pos, clken}, {5'd1, 3'b111});
                end
            end
            if (k == 5) begin
                n_cmp++;
                if ({pos, clken} !== {5'd5, 3'b001}) begin
                    n_bad++;
                    $display("FAIL pos4_pulse: got %b required %b",
                             {pos, clken}, {5'd5, 3'b001});
                end
            end
        end
        n_cmp++;
        if (c0 != 4 || c1 != 1 || c2 != 1 || fs_at != 25) begin
            n_bad++;
            $display("FAIL t0_counts: got %0d/%0d/%0d fs@%0d required 4/1/1 fs@25",
                     c0, c1, c2, fs_at);
        end
    endtask

    task automatic test_turbo();
        int c0 = 0, c1 = 0, c2 = 0;
        wait_pos(7);
        turbo = 2;
        repeat (18) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
        end
        n_cmp++;
        if (c0 != 2 || c1 != 0) begin
            n_bad++;
            $display("FAIL turbo_midframe: got %0d/%0d required 2/0", c0, c1);
        end
        c0 = 0; c1 = 0;
        repeat (25) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
            if (clken[2]) c2++;
        end
        n_cmp++;
        if (c0 != 16 || c1 != 4 || c2 != 4) begin
            n_bad++;
            $display("FAIL turbo2_frame: got %0d/%0d/%0d required 16/4/4",
                     c0, c1, c2);
        end
    endtask

    task automatic test_turbo3();
        int c0 = 0, c1 = 0, c2 = 0;
        turbo = 3;
        wait_pos(0);
        repeat (25) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
            if (clken[2]) c2++;
        end
        n_cmp++;
        if (c0 != 16 || c1 != 4 || c2 != 4) begin
            n_bad++;
            $display("FAIL turbo3_clamp: got %0d/%0d/%0d required 16/4/4",
                     c0, c1, c2);
        end
    endtask

    task automatic test_pause();
        int c0 = 0, c1 = 0, c2 = 0;
        turbo = 0;
        wait_pos(0);
        wait_pos(10);
        pause_req = 1;
        wait_pos(0);
        n_cmp++;
        if (pause_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_early: got %b required 0", pause_ack);
        end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
            if (clken[2]) c2++;
            if (k == 1) begin
                n_cmp++;
                if ({pause_ack, clken[0]} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL ack_rise: got %b required 10",
                             {pause_ack, clken[0]});
                end
            end
        end
        n_cmp++;
        if (c0 != 0 || c1 != 1 || c2 != 1) begin
            n_bad++;
            $display("FAIL paused_counts: got %0d/%0d/%0d required 0/1/1",
                     c0, c1, c2);
        end
        pause_req = 0;
        wait_pos(0);
        n_cmp++;
        if (pause_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_hold: got %b required 1", pause_ack);
        end
        @(negedge clk);
        n_cmp++;
        if ({pause_ack, clken} !== 4'b0111) begin
            n_bad++;
            $display("FAIL resume: got %b required 0111", {pause_ack, clken});
        end
    endtask

    task automatic test_pulse();
        int acks = 0, c0 = 0;
        wait_pos(3);
        pause_req = 1;
        wait_pos(6);
        pause_req = 0;
        wait_pos(0);
        repeat (25) begin
            @(negedge clk);
            if (pause_ack) acks++;
            if (clken[0]) c0++;
        end
        n_cmp++;
        if (acks != 0 || c0 != 4) begin
            n_bad++;
            $display("FAIL short_pulse: got ack %0d ch0 %0d required 0/4",
                     acks, c0);
        end
    endtask

    task automatic test_wrap_edge();
        int c0 = 0, c1 = 0;
        wait_pos(24);
        turbo = 2;
        pause_req = 1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (clken[0]) c0++;
            if (clken[1]) c1++;
            if (k == 2) begin
                n_cmp++;
                if (pause_ack !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_raise_ack: got %b required 1", pause_ack);
                end
            end
        end
        n_cmp++;
        if (c0 != 0 || c1 != 4) begin
            n_bad++;
            $display("FAIL wrap_both: got %0d/%0d required 0/4", c0, c1);
        end
        pause_req = 0;
        turbo = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({pause_ack, clken} !== 4'b0111) begin
            n_bad++;
            $display("FAIL wrap_drop: got %b required 0111", {pause_ack, clken});
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            got = {pos, clken, clken0_d1, frame_start, pause_ack};
            exp = {5'(m_pos), m_clken, m_d1, m_fs, m_ack};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random k=%0d: got %b required %b", k, got, exp);
            end
            if (!reset_n) reset_n = 1;
            else if ($urandom_range(0, 299) == 0) reset_n = 0;
            if ($urandom_range(0, 7) == 0) turbo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pause_req = ~pause_req;
        end
        reset_n = 1;
    endtask

    task automatic test_reset_mid();
        int c0 = 0, fs_at = -1;
        turbo = 0;
        pause_req = 1;
        wait_pos(0);
        wait_pos(0);
        wait_pos(12);
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if ({pos, clken, clken0_d1, frame_start, pause_ack} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %b required 0",
                     {pos, clken, clken0_d1, frame_start, pause_ack});
        end
        turbo = 2;
        pause_req = 0;
        @(negedge clk);
        reset_n = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 25 && clken[0]) c0++;
            if (frame_start && fs_at < 0) fs_at = k;
            if (k == 1) begin
                n_cmp++;
                if (pos !== 5'd1) begin
                    n_bad++;
                    $display("FAIL restart_pos: got %0d required 1", pos);
                end
            end
        end
        n_cmp++;
        if (c0 != 4 || fs_at != 25) begin
            n_bad++;
            $display("FAIL post_reset: got ch0 %0d fs@%0d required 4 fs@25",
                     c0, fs_at);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_turbo();
        test_turbo3();
        test_pause();
        test_pulse();
        test_wrap_edge();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
